// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and turns per-opcode control into timed strobes.
module cpu_sequencer #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_fetch,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_we,
  output logic       retire,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [TIMEOUT_W-1:0] WDOG_ONE = TIMEOUT_W'(1);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  logic   legal_op, is_store, is_ldst, timeout;
  state_t after_retire;

  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: legal_op = 1'b1;
      default:                           legal_op = 1'b0;
    endcase
  end

  assign is_store     = (opcode == OP_STORE);
  assign is_ldst      = is_store || (opcode == OP_LOAD);
  assign after_retire = stall ? S_IDLE : S_FETCH;
  // The 2^W-th consecutive wait cycle is the one entered with the counter saturated.
  assign timeout      = (wdog_q == '1) && !mem_ready;

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    reg_we       = 1'b0;
    retire       = 1'b0;
    fault        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!stall) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        state_d = legal_op ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        if (is_ldst) begin
          state_d = S_MEM;
        end else if (opcode == OP_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = after_retire;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = after_retire;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        if (opcode == OP_JAL)       pc_sel = 2'b01;
        else if (opcode == OP_JALR) pc_sel = 2'b10;
        state_d = after_retire;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  always_comb begin
    if ((state_d != state_q) || !mem_req || mem_ready) wdog_d = '0;
    else                                               wdog_d = wdog_q + WDOG_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst, stall, mem_ready, branch_taken;
  logic [6:0] opcode;
  logic       mem_req, mem_we, mem_is_fetch, ir_we, pc_we, reg_we, retire, fault;
  logic [1:0] pc_sel;
  logic [2:0] state;

  cpu_sequencer #(.TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .retire(retire), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] F_REQ = 10'h001, F_WE   = 10'h002, F_IF   = 10'h004;
  localparam logic [9:0] F_IR  = 10'h008, F_PCWE = 10'h010, F_SEL1 = 10'h020;
  localparam logic [9:0] F_SEL2 = 10'h040, F_RWE = 10'h080, F_RET  = 10'h100;
  localparam logic [9:0] F_FLT = 10'h200;
  localparam logic [9:0] FETCH_OK = F_REQ | F_IF | F_IR;
  localparam logic [9:0] FETCH_WT = F_REQ | F_IF;
  localparam logic [9:0] WB_F     = F_RWE | F_PCWE | F_RET;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DEC = 3'd2, EXEC = 3'd3;
  localparam logic [2:0] MEM  = 3'd4, WB = 3'd5, FLT = 3'd7;

  localparam logic [6:0] OP_ALU = 7'b0110011, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  st;
    logic [9:0]  fl;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  string       phase = "reset";

  wire [9:0] dut_fl = {fault, retire, reg_we, pc_sel, pc_we, ir_we,
                       mem_is_fetch, mem_we, mem_req};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got state=%0d strobes=%h, expected state=%0d strobes=%h",
               name, cyc, act[12:10], act[9:0], exp[12:10], exp[9:0]);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) chk({e.tag, "_missed"}, 13'h1fff, {e.st, e.fl});
      else             chk(e.tag, {state, dut_fl}, {e.st, e.fl});
    end
  end

  task automatic step(input logic [2:0] st, input logic [9:0] fl);
    sb.push_back('{cyc: cyc, st: st, fl: fl, tag: phase});
    @(posedge clk);
    #1;
  endtask

  // Raises rst mid-cycle and checks the asynchronous drop before releasing it.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk({phase, "_async_rst"}, {state, dut_fl}, 13'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: got no completion, expected finish before 200000ns");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1; stall = 1'b0; mem_ready = 1'b0; opcode = '0; branch_taken = 1'b0;
    #2;
    do_reset();

    phase = "alu"; opcode = OP_ALU; mem_ready = 1'b1;
    step(IDLE, 10'h0);
    for (int i = 0; i < 2; i++) begin
      step(FETCH, FETCH_OK); step(DEC, 10'h0); step(EXEC, 10'h0); step(WB, WB_F);
    end

    phase = "br_taken"; opcode = OP_BR; branch_taken = 1'b1;
    step(FETCH, FETCH_OK); step(DEC, 10'h0); step(EXEC, F_PCWE | F_SEL1 | F_RET);
    phase = "br_not_taken"; branch_taken = 1'b0;
    step(FETCH, FETCH_OK); step(DEC, 10'h0); step(EXEC, F_PCWE | F_RET);

    phase = "load_wait"; opcode = OP_LD;
    step(FETCH, FETCH_OK); step(DEC, 10'h0); step(EXEC, 10'h0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(MEM, F_REQ);
    mem_ready = 1'b1;
    step(MEM, F_REQ); step(WB, WB_F);

    phase = "store"; opcode = OP_ST;
    step(FETCH, FETCH_OK); step(DEC, 10'h0); step(EXEC, 10'h0);
    mem_ready = 1'b0;
    step(MEM, F_REQ | F_WE);
    mem_ready = 1'b1;
    step(MEM, F_REQ | F_WE | F_PCWE | F_RET);

    phase = "jal"; opcode = OP_JAL;
    step(FETCH, FETCH_OK); step(DEC, 10'h0); step(EXEC, 10'h0); step(WB, WB_F | F_SEL1);
    phase = "jalr"; opcode = OP_JALR;
    step(FETCH, FETCH_OK); step(DEC, 10'h0); step(EXEC, 10'h0); step(WB, WB_F | F_SEL2);
    phase = "lui"; opcode = OP_LUI;
    step(FETCH, FETCH_OK); step(DEC, 10'h0); step(EXEC, 10'h0); step(WB, WB_F);

    phase = "stall"; opcode = OP_ALU;
    step(FETCH, FETCH_OK);
    stall = 1'b1;
    step(DEC, 10'h0); step(EXEC, 10'h0); step(WB, WB_F); step(IDLE, 10'h0);
    stall = 1'b0;
    step(IDLE, 10'h0);

    phase = "rst_mid_mem"; opcode = OP_LD;
    step(FETCH, FETCH_OK); step(DEC, 10'h0); step(EXEC, 10'h0);
    mem_ready = 1'b0;
    chk("rst_mid_mem_pre", {state, dut_fl}, {MEM, F_REQ});
    do_reset();

    phase = "illegal_op"; opcode = 7'b0000000; mem_ready = 1'b1;
    step(IDLE, 10'h0); step(FETCH, FETCH_OK); step(DEC, 10'h0);
    for (int i = 0; i < 20; i++) begin
      stall = i[0]; mem_ready = i[1]; branch_taken = i[2];
      step(FLT, F_FLT);
    end
    stall = 1'b0; branch_taken = 1'b0;
    do_reset();

    phase = "wdog_fault"; opcode = OP_ALU; mem_ready = 1'b0;
    step(IDLE, 10'h0);
    for (int i = 0; i < 256; i++) step(FETCH, FETCH_WT);
    step(FLT, F_FLT); step(FLT, F_FLT);
    do_reset();

    phase = "wdog_edge";
    step(IDLE, 10'h0);
    for (int i = 0; i < 255; i++) step(FETCH, FETCH_WT);
    mem_ready = 1'b1;
    step(FETCH, FETCH_OK); step(DEC, 10'h0); step(EXEC, 10'h0);
    stall = 1'b1;
    step(WB, WB_F); step(IDLE, 10'h0);

    @(posedge clk); #1;
    chk("scoreboard_drained", 13'(sb.size()), 13'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back phases. It drives the shared memory port handshake and generates per-phase write enables for the PC, IR and register file. Opcode classification comes from IR[6:0]. It sits between the instruction register and the datapath enables, and converts per-opcode static control into time-sequenced strobes.

## Interface
- TIMEOUT_W, 8, width of the memory-wait watchdog counter; a request stalled for 2^TIMEOUT_W consecutive cycles faults.

- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold request; sampled only at instruction boundaries
- opcode  in  7  IR[6:0]; the datapath holds it stable from DECODE until the instruction retires
- mem_ready  in  1  memory accepts/completes the current request in this cycle
- branch_taken  in  1  ALU compare result, sampled in EXEC
- mem_req  out  1  memory request active
- mem_we  out  1  request is a store
- mem_is_fetch  out  1  request is an instruction fetch
- ir_we  out  1  latch the fetched word into IR
- pc_we  out  1  PC update strobe
- pc_sel  out  2  00 PC+4, 01 PC+imm (branch/JAL), 10 ALU result (JALR)
- reg_we  out  1  register-file write strobe
- retire  out  1  one-cycle pulse when an instruction completes
- fault  out  1  high in FAULT
- state  out  3  current state encoding

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. Code 6 is unused and goes to FAULT.
- All outputs are Moore-decoded from the state register. Exceptions: ir_we, pc_we, pc_sel, reg_we and retire may also depend on mem_ready, opcode and branch_taken in the current cycle.
- "next" means: IDLE if stall=1, else FETCH.
- IDLE: all strobes 0. Go to FETCH when stall=0.
- FETCH: mem_req=1, mem_is_fetch=1. When mem_ready=1, ir_we=1 in the same cycle and the next state is DECODE. Otherwise stay in FETCH.
- DECODE: no strobes. The legal opcode set is 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011 and 0110011.
  - Legal opcode: go to EXEC.
  - Any other opcode: go to FAULT.
- EXEC:
  - Load/store: go to MEM.
  - Branch: pc_we=1, pc_sel=01 if branch_taken else 00, retire=1, then go to next.
  - Any other opcode: go to WB.
- MEM: mem_req=1, mem_we=1 for stores, mem_is_fetch=0. Stay until mem_ready=1, then:
  - Store: pc_we=1, pc_sel=00, retire=1, then go to next.
  - Load: go to WB.
- WB: reg_we=1, pc_we=1, retire=1, then go to next. pc_sel is 01 for JAL, 10 for JALR, 00 otherwise.
- FAULT: all strobes 0, fault=1. It is sticky; only rst leaves it.
- Watchdog:
  - The counter increments each cycle that mem_req=1 and mem_ready=0.
  - It clears on mem_ready=1 and on every state change.
  - If mem_ready is still 0 in the 2^TIMEOUT_W-th consecutive wait cycle, the next state is FAULT.
  - mem_ready=1 in that cycle wins, and the request completes normally.

## Timing
- Reset: state=IDLE, counter=0. All outputs are 0, including fault and state=0. Reset is asynchronous, so outputs drop in the same cycle rst rises.
- A reset mid-transaction abandons the in-flight memory request; mem_req falls immediately.
- The first FETCH is the cycle after rst deasserts with stall=0.
- A request completes in any cycle with mem_req&&mem_ready=1, including its first cycle (zero-wait).
- Instruction lengths with zero-wait memory:
  - Branch: 3 cycles (FETCH, DECODE, EXEC).
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds one cycle.
- Back-to-back: the retire cycle is followed directly by FETCH, with no bubble, when stall=0.
- stall raised mid-instruction does not abort it. It takes effect at retire, and the FSM enters IDLE on the next edge.
- ir_we, pc_we, reg_we and retire are each at most one cycle per instruction.
- mem_req never asserts in DECODE, EXEC, WB, IDLE or FAULT.

## Test plan
- Reset, stall=0, mem_ready=1, opcode=0110011 → state sequence 0,1,2,3,5,1.
  - ir_we=1 in FETCH.
  - reg_we, pc_we and retire=1 in WB with pc_sel=00.
  - Retire pulses repeat every 4 cycles.
- Branch 1100011:
  - branch_taken=1 → EXEC shows pc_we=1, pc_sel=01, retire=1, reg_we=0, then FETCH.
  - branch_taken=0 → pc_sel=00.
- Load 0000011 with mem_ready low for 3 MEM cycles → mem_req=1 and mem_we=0 throughout, then WB with reg_we=1. Instruction length is 8 cycles.
- Store 0100011 → mem_we=1 in MEM, reg_we never asserts, retire and pc_we coincide with mem_ready.
- Fault cases:
  - opcode=0000000 → FAULT after DECODE, fault=1, all strobes 0, held through 20 cycles until rst.
  - TIMEOUT_W=8 with mem_ready low for 256 FETCH cycles → FAULT.
  - Same, but mem_ready high in the 256th cycle → DECODE.
- stall=1 during WB → retire occurs, then IDLE; stall=0 → FETCH next cycle. rst asserted mid-MEM → mem_req and state are 0 in the same cycle.
